hazard_control_unit: RTL and testbench

//  Pipeline stall/flush controller for the 5-stage RV32 core; peer of the forwarding unit in ID/EX.

---
 rtl/hazard_control_unit_pkg.sv | 35 +++
 rtl/hazard_control_unit_if.sv | 49 ++++
 rtl/hazard_control_unit_sat_counter.sv | 22 ++
 rtl/hazard_control_unit.sv | 158 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings and FSM states for the pipeline hazard controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hazard_control_unit_pkg;

  // RV32I major opcodes the hazard logic needs to recognise.
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_DMEM_WAIT  = 2'd1,
    ST_FETCH_KILL = 2'd2
  } hcu_state_e;

  // A load in EX whose rd feeds the ID instruction cannot be forwarded in time.
  // Store data (rs2) is picked up later by the MEM-stage forward, so it is
  // exempt; the store base address (rs1) is needed in EX and is not.
  function automatic logic is_load_use(
    input logic [6:0] exe_opcode,
    input logic [4:0] exe_addr,
    input logic [6:0] id_opcode,
    input logic [4:0] id_addr1,
    input logic [4:0] id_addr2,
    input logic       id_rs1_used,
    input logic       id_rs2_used
  );
    logic rs1_hit;
    logic rs2_hit;
    rs1_hit = id_rs1_used && (id_addr1 == exe_addr);
    rs2_hit = id_rs2_used && (id_addr2 == exe_addr) && (id_opcode != OPC_STORE);
    return (exe_opcode == OPC_LOAD) && (exe_addr != 5'd0) && (rs1_hit || rs2_hit);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle between the pipeline and the hazard controller: hazard sources in, control out.
// Latency: wires only.
// Backpressure: n/a; stall/flush outputs are themselves the pipeline backpressure.
// slave  : hazard controller side (sources in, controls and counters out)
// master : pipeline side (drives sources, consumes controls)
interface hazard_control_unit_if #(
  parameter int CNT_WIDTH = 16
);
  // hazard sources
  logic [4:0]           id_addr1;
  logic [4:0]           id_addr2;
  logic                 id_rs1_used;
  logic                 id_rs2_used;
  logic [6:0]           id_opcode;
  logic [4:0]           exe_addr;
  logic [6:0]           exe_opcode;
  logic                 branch_taken;
  logic                 imem_busy;
  logic                 dmem_busy;
  // pipeline register controls
  logic                 pc_stall;
  logic                 ifid_stall;
  logic                 ifid_flush;
  logic                 idex_stall;
  logic                 idex_bubble;
  logic                 exmem_stall;
  logic                 memwb_bubble;
  // status
  logic                 mem_timeout_err;
  logic [CNT_WIDTH-1:0] load_stall_cnt;
  logic [CNT_WIDTH-1:0] branch_flush_cnt;
  logic [CNT_WIDTH-1:0] mem_stall_cnt;

  modport slave (
    input  id_addr1, id_addr2, id_rs1_used, id_rs2_used, id_opcode,
           exe_addr, exe_opcode, branch_taken, imem_busy, dmem_busy,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           exmem_stall, memwb_bubble, mem_timeout_err,
           load_stall_cnt, branch_flush_cnt, mem_stall_cnt
  );

  modport master (
    output id_addr1, id_addr2, id_rs1_used, id_rs2_used, id_opcode,
           exe_addr, exe_opcode, branch_taken, imem_busy, dmem_busy,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           exmem_stall, memwb_bubble, mem_timeout_err,
           load_stall_cnt, branch_flush_cnt, mem_stall_cnt
  );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
// Latency: count visible the cycle after the increment.
// Backpressure: none; increments past saturation are dropped.
// Ports: clk, rst (async, active-high), inc, cnt[CNT_WIDTH-1:0]
module hazard_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage RV32 pipeline (load-use, branch kill, IMEM/DMEM wait).
// Latency: controls are Mealy, same cycle as the hazard inputs; counters/error flag one cycle later.
// Backpressure: DMEM busy freezes PC..EX/MEM and bubbles MEM/WB; IMEM busy holds PC and flushes IF/ID.
// Ports: clk, rst (async, active-high), hz (hazard_control_unit_if.slave: sources in,
//        stall/flush/bubble controls, timeout flag and three saturating counters out)
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  hazard_control_unit_if.slave hz
);

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);
  // Timer value during the last busy cycle before the timeout: the first busy
  // cycle is spent in RUN, so DMEM_WAIT starts counting from the second one.
  localparam logic [TW-1:0] TIMER_ERR  = TW'(MEM_TIMEOUT - 2);

  hcu_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic          load_use;
  logic          load_inc, branch_inc;

  logic pc_stall, ifid_stall, ifid_flush, idex_stall;
  logic idex_bubble, exmem_stall, memwb_bubble;

  assign load_use = is_load_use(hz.exe_opcode, hz.exe_addr, hz.id_opcode,
                                hz.id_addr1, hz.id_addr2,
                                hz.id_rs1_used, hz.id_rs2_used);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    err_d        = err_q;
    load_inc     = 1'b0;
    branch_inc   = 1'b0;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;

    if (rst) begin
      // Drain everything while in reset so no stale instruction retires.
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      case (state_q)
        // DMEM_WAIT releases into exactly the RUN decision, so both share one arm.
        ST_RUN, ST_DMEM_WAIT: begin
          if (hz.dmem_busy) begin
            // Freeze: EX is held, so branch/load-use get re-evaluated after release.
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
            state_d      = ST_DMEM_WAIT;
            if (state_q == ST_DMEM_WAIT) begin
              timer_d = (timer_q == TIMER_LAST) ? timer_q : timer_q + 1'b1;
              if (timer_q == TIMER_ERR) begin
                err_d = 1'b1;
              end
            end
          end else begin
            state_d = ST_RUN;
            if (hz.branch_taken) begin
              // ID holds a wrong-path instruction; killing it also voids any load-use.
              ifid_flush  = 1'b1;
              idex_bubble = 1'b1;
              branch_inc  = 1'b1;
              if (hz.imem_busy) begin
                state_d = ST_FETCH_KILL;
              end
            end else if (load_use) begin
              pc_stall    = 1'b1;
              ifid_stall  = 1'b1;
              idex_bubble = 1'b1;
              load_inc    = 1'b1;
            end else if (hz.imem_busy) begin
              pc_stall   = 1'b1;
              ifid_flush = 1'b1;
            end
          end
        end

        ST_FETCH_KILL: begin
          // Fetch in flight belongs to the wrong path: discard it, including
          // the word that lands on the cycle imem_busy drops.
          pc_stall   = 1'b1;
          ifid_flush = 1'b1;
          if (hz.dmem_busy) begin
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
          end
          if (!hz.imem_busy) begin
            state_d = hz.dmem_busy ? ST_DMEM_WAIT : ST_RUN;
          end
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

  assign hz.pc_stall        = pc_stall;
  assign hz.ifid_stall      = ifid_stall;
  assign hz.ifid_flush      = ifid_flush;
  assign hz.idex_stall      = idex_stall;
  assign hz.idex_bubble     = idex_bubble;
  assign hz.exmem_stall     = exmem_stall;
  assign hz.memwb_bubble    = memwb_bubble;
  assign hz.mem_timeout_err = err_q;

  hazard_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_load_cnt (
    .clk (clk),
    .rst (rst),
    .inc (load_inc),
    .cnt (hz.load_stall_cnt)
  );

  hazard_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (branch_inc),
    .cnt (hz.branch_flush_cnt)
  );

  hazard_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mem_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hz.dmem_busy),
    .cnt (hz.mem_stall_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  localparam int CW   = 4;
  localparam int MT   = 64;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  // control vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_bubble}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_RESET  = 7'b0010101;
  localparam logic [6:0] C_LOAD   = 7'b1100100;
  localparam logic [6:0] C_BRANCH = 7'b0010100;
  localparam logic [6:0] C_FETCH  = 7'b1010000;
  localparam logic [6:0] C_FREEZE = 7'b1101011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.CNT_WIDTH(CW)) hz ();

  hazard_control_unit #(.CNT_WIDTH(CW), .MEM_TIMEOUT(MT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a wrong-path fetch pending flag, a run length of dmem_busy,
  // and plain integer counters.
  bit m_kill;
  int m_streak;
  bit m_err;
  int m_load, m_br, m_mem;

  function automatic void m_clear();
    m_kill = 0; m_streak = 0; m_err = 0;
    m_load = 0; m_br = 0; m_mem = 0;
  endfunction

  function automatic bit m_load_use();
    if (hz.exe_opcode != OP_LOAD || hz.exe_addr == 5'd0) return 0;
    if (hz.id_rs1_used && hz.id_addr1 == hz.exe_addr) return 1;
    if (hz.id_rs2_used && hz.id_addr2 == hz.exe_addr && hz.id_opcode != OP_STORE) return 1;
    return 0;
  endfunction

  function automatic logic [6:0] m_ctrl();
    if (rst) return C_RESET;
    if (hz.dmem_busy) return m_kill ? (C_FREEZE | C_FETCH) : C_FREEZE;
    if (m_kill) return C_FETCH;
    if (hz.branch_taken) return C_BRANCH;
    if (m_load_use()) return C_LOAD;
    if (hz.imem_busy) return C_FETCH;
    return C_NONE;
  endfunction

  function automatic void m_step();
    if (rst) begin
      m_clear();
      return;
    end
    if (hz.dmem_busy) begin
      if (m_mem < CMAX) m_mem++;
      m_streak++;
      if (m_streak >= MT) m_err = 1;
    end else begin
      m_streak = 0;
    end
    if (!hz.dmem_busy && !m_kill) begin
      if (hz.branch_taken) begin
        if (m_br < CMAX) m_br++;
      end else if (m_load_use()) begin
        if (m_load < CMAX) m_load++;
      end
    end
    m_kill = m_kill ? hz.imem_busy : (!hz.dmem_busy && hz.branch_taken && hz.imem_busy);
  endfunction

  function automatic logic [6:0] dut_ctrl();
    return {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_stall,
            hz.idex_bubble, hz.exmem_stall, hz.memwb_bubble};
  endfunction

  task automatic drive(input logic [6:0] eop, input logic [4:0] erd, input logic [6:0] iop,
                       input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                       input logic br, input logic im, input logic dm);
    hz.exe_opcode   = eop;
    hz.exe_addr     = erd;
    hz.id_opcode    = iop;
    hz.id_addr1     = a1;
    hz.id_addr2     = a2;
    hz.id_rs1_used  = u1;
    hz.id_rs2_used  = u2;
    hz.branch_taken = br;
    hz.imem_busy    = im;
    hz.dmem_busy    = dm;
  endtask

  task automatic idle();
    drive(OP_ALU, 5'd0, OP_ALU, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Load-use: EX=LOAD rd=1, ID R-type reading x3 and x1.
  task automatic drive_lu(input logic dm);
    drive(OP_LOAD, 5'd1, OP_ALU, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, dm);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_clear();
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_clear();
    drive(OP_LOAD, 5'd1, OP_ALU, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (dut_ctrl() !== C_RESET) begin
        fails++;
        $display("FAIL reset_ctrl cyc %0d: got %b expected %b", i, dut_ctrl(), C_RESET);
      end
      tests++;
      if ({hz.load_stall_cnt, hz.branch_flush_cnt, hz.mem_stall_cnt, hz.mem_timeout_err} !== '0) begin
        fails++;
        $display("FAIL reset_status cyc %0d: got ld=%0d br=%0d mem=%0d err=%b expected all 0",
                 i, hz.load_stall_cnt, hz.branch_flush_cnt, hz.mem_stall_cnt, hz.mem_timeout_err);
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    drive_lu(1'b0);
    @(negedge clk);
    tests++;
    if (dut_ctrl() !== C_LOAD) begin
      fails++; $display("FAIL load_use_ctrl: got %b expected %b", dut_ctrl(), C_LOAD);
    end
    tick();
    idle();
    @(negedge clk);
    tests++;
    if (dut_ctrl() !== C_NONE) begin
      fails++; $display("FAIL load_use_one_cycle: got %b expected %b", dut_ctrl(), C_NONE);
    end
    tests++;
    if (hz.load_stall_cnt !== 4'd1) begin
      fails++; $display("FAIL load_use_cnt: got %0d expected 1", hz.load_stall_cnt);
    end
    tick();
  endtask

  task automatic test_store();
    do_reset();
    drive(OP_LOAD, 5'd1, OP_STORE, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (dut_ctrl() !== C_NONE) begin
      fails++; $display("FAIL store_data_exempt: got %b expected %b", dut_ctrl(), C_NONE);
    end
    tick();
    drive(OP_LOAD, 5'd1, OP_STORE, 5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (dut_ctrl() !== C_LOAD) begin
      fails++; $display("FAIL store_base_stall: got %b expected %b", dut_ctrl(), C_LOAD);
    end
    tick();
    drive(OP_LOAD, 5'd0, OP_ALU, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (dut_ctrl() !== C_NONE) begin
      fails++; $display("FAIL load_x0_exempt: got %b expected %b", dut_ctrl(), C_NONE);
    end
    tick();
    idle();
  endtask

  task automatic test_branch_kill();
    logic [6:0] exp [5] = '{C_BRANCH, C_FETCH, C_FETCH, C_FETCH, C_NONE};
    int nflush = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(OP_ALU, 5'd0, OP_ALU, 5'd0, 5'd0, 1'b0, 1'b0, i == 0, i < 3, 1'b0);
      @(negedge clk);
      if (hz.ifid_flush === 1'b1) nflush++;
      tests++;
      if (dut_ctrl() !== exp[i]) begin
        fails++; $display("FAIL branch_kill_ctrl cyc %0d: got %b expected %b", i, dut_ctrl(), exp[i]);
      end
      tick();
    end
    tests++;
    if (nflush != 4) begin
      fails++; $display("FAIL branch_kill_flush_cycles: got %0d expected 4", nflush);
    end
    tests++;
    if (hz.branch_flush_cnt !== 4'd1) begin
      fails++; $display("FAIL branch_flush_cnt: got %0d expected 1", hz.branch_flush_cnt);
    end
  endtask

  task automatic test_dmem_freeze();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_lu(i < 5);
      @(negedge clk);
      tests++;
      if (dut_ctrl() !== ((i < 5) ? C_FREEZE : C_LOAD)) begin
        fails++;
        $display("FAIL dmem_freeze_ctrl cyc %0d: got %b expected %b", i, dut_ctrl(), (i < 5) ? C_FREEZE : C_LOAD);
      end
      tick();
    end
    idle();
    @(negedge clk);
    tests++;
    if (hz.mem_stall_cnt !== 4'd5 || hz.load_stall_cnt !== 4'd1) begin
      fails++;
      $display("FAIL dmem_freeze_cnt: got mem=%0d ld=%0d expected mem=5 ld=1", hz.mem_stall_cnt, hz.load_stall_cnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < MT; i++) begin
      drive(OP_ALU, 5'd0, OP_ALU, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      tests++;
      if (hz.mem_timeout_err !== 1'b0 || dut_ctrl() !== C_FREEZE) begin
        fails++;
        $display("FAIL timeout_early cyc %0d: got err=%b ctrl=%b expected err=0 ctrl=%b",
                 i, hz.mem_timeout_err, dut_ctrl(), C_FREEZE);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      @(negedge clk);
      tests++;
      if (hz.mem_timeout_err !== 1'b1 || dut_ctrl() !== C_NONE) begin
        fails++;
        $display("FAIL timeout_sticky cyc %0d: got err=%b ctrl=%b expected err=1 ctrl=%b",
                 i, hz.mem_timeout_err, dut_ctrl(), C_NONE);
      end
      tick();
    end
    tests++;
    if (hz.mem_stall_cnt !== 4'(CMAX)) begin
      fails++; $display("FAIL mem_cnt_saturate: got %0d expected %0d", hz.mem_stall_cnt, CMAX);
    end
    do_reset();
    @(negedge clk);
    tests++;
    if (hz.mem_timeout_err !== 1'b0) begin
      fails++; $display("FAIL timeout_cleared: got %b expected 0", hz.mem_timeout_err);
    end
    tick();
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_lu(1'b0);
      tick();
      idle();
      tick();
    end
    @(negedge clk);
    tests++;
    if (hz.load_stall_cnt !== 4'(CMAX)) begin
      fails++; $display("FAIL load_cnt_saturate: got %0d expected %0d", hz.load_stall_cnt, CMAX);
    end
    tick();
    drive(OP_ALU, 5'd0, OP_ALU, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(OP_ALU, 5'd0, OP_ALU, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (dut_ctrl() !== C_FETCH) begin
      fails++; $display("FAIL fetch_kill_entry: got %b expected %b", dut_ctrl(), C_FETCH);
    end
    #1;
    rst = 1'b1;
    m_clear();
    #1;
    tests++;
    if (dut_ctrl() !== C_RESET || {hz.load_stall_cnt, hz.branch_flush_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_mid_kill: got ctrl=%b ld=%0d br=%0d expected ctrl=%b ld=0 br=0",
               dut_ctrl(), hz.load_stall_cnt, hz.branch_flush_cnt, C_RESET);
    end
    rst = 1'b0;
    drive_lu(1'b0);
    #1;
    tests++;
    if (dut_ctrl() !== C_LOAD) begin
      fails++; $display("FAIL run_after_reset: got %b expected %b", dut_ctrl(), C_LOAD);
    end
    tick();
    idle();
    @(negedge clk);
    tests++;
    if (hz.load_stall_cnt !== 4'd1) begin
      fails++; $display("FAIL load_cnt_after_reset: got %0d expected 1", hz.load_stall_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (rst) m_clear();
      drive(($urandom_range(0, 1) == 0) ? OP_LOAD : (($urandom_range(0, 1) == 0) ? OP_ALU : OP_BR),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? OP_STORE : OP_ALU,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      @(negedge clk);
      tests++;
      if ({dut_ctrl(), hz.mem_timeout_err} !== {m_ctrl(), m_err}) begin
        fails++;
        $display("FAIL random_ctrl cyc %0d: got %b/%b expected %b/%b", i, dut_ctrl(), hz.mem_timeout_err, m_ctrl(), m_err);
      end
      tests++;
      if (int'(hz.load_stall_cnt) != m_load || int'(hz.branch_flush_cnt) != m_br || int'(hz.mem_stall_cnt) != m_mem) begin
        fails++;
        $display("FAIL random_cnt cyc %0d: got ld=%0d br=%0d mem=%0d expected ld=%0d br=%0d mem=%0d",
                 i, hz.load_stall_cnt, hz.branch_flush_cnt, hz.mem_stall_cnt, m_load, m_br, m_mem);
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    m_clear();
    idle();
    test_reset();
    test_load_use();
    test_store();
    test_branch_kill();
    test_dmem_freeze();
    test_timeout();
    test_saturate_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
